// File: rtl/hni_txrsp_ctl.sv
// HNI TX RSP channel controller: link credit counter, 2-way requester arbiter and deactivation credit return.
// Optional macro HNI_TXRSP_QOS_PRIO_EN: QoS-priority arbitration ahead of round-robin on contention.

`ifndef CHIE_RSP_FLIT_RANGE
`define CHIE_RSP_FLIT_RANGE 72:0
`endif
`ifndef CHIE_RSP_FLIT_QOS_RANGE
`define CHIE_RSP_FLIT_QOS_RANGE 3:0
`endif
`ifndef HNI_LL_RSP_CRD_CNT_WIDTH
`define HNI_LL_RSP_CRD_CNT_WIDTH 4
`endif

module hni_txrsp_ctl #(
    parameter int unsigned HNI_TXRSP_MAX_CRD = 15
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       txrsp_lcrdv,
    input  logic                       txrsp_deact_req,
    input  logic                       req0_valid,
    input  logic [`CHIE_RSP_FLIT_RANGE] req0_flit,
    input  logic                       req1_valid,
    input  logic [`CHIE_RSP_FLIT_RANGE] req1_flit,
    output logic                       req0_ready,
    output logic                       req1_ready,
    output logic                       txrspflitpend,
    output logic                       txrspflitv,
    output logic [`CHIE_RSP_FLIT_RANGE] txrspflit,
    output logic                       txrsp_deact_done,
    output logic                       txrsp_crd_ovf
);

    localparam int CW = `HNI_LL_RSP_CRD_CNT_WIDTH;
    localparam logic [CW-1:0] MAX_CRD = CW'(HNI_TXRSP_MAX_CRD);

    typedef enum logic [1:0] {ST_RUN, ST_RETURN, ST_DONE} state_e;

    state_e                      state_q, state_d;
    logic [CW-1:0]               cnt_q, cnt_d;
    logic                        ptr_q, ptr_d;
    logic                        flitv_q, flitv_d;
    logic [`CHIE_RSP_FLIT_RANGE] flit_q, flit_d;
    logic                        pend_q, pend_d;
    logic                        ovf_q, ovf_d;
    logic                        done_q, done_d;

    logic grant_en;
    logic win0_both;
    logic lcrd_ret;
    logic issue;

    // ptr_q == 1 means requester 1 was granted last, so requester 0 wins a tie.
`ifdef HNI_TXRSP_QOS_PRIO_EN
    logic [`CHIE_RSP_FLIT_QOS_RANGE] qos0, qos1;
    assign qos0      = req0_flit[`CHIE_RSP_FLIT_QOS_RANGE];
    assign qos1      = req1_flit[`CHIE_RSP_FLIT_QOS_RANGE];
    assign win0_both = (qos0 > qos1) | ((qos0 == qos1) & ptr_q);
`else
    assign win0_both = ptr_q;
`endif

    assign grant_en   = (state_q == ST_RUN) & (cnt_q != '0);
    assign req0_ready = grant_en & req0_valid & (~req1_valid | win0_both);
    assign req1_ready = grant_en & req1_valid & (~req0_valid | ~win0_both);
    assign lcrd_ret   = (state_q == ST_RETURN) & (cnt_q != '0);
    assign issue      = req0_ready | req1_ready | lcrd_ret;

    always_comb begin
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        ptr_d   = ptr_q;
        state_d = state_q;
        flitv_d = issue;
        flit_d  = '0;
        pend_d  = ((state_q == ST_RUN) & (req0_valid | req1_valid)) | (state_q == ST_RETURN);

        if (req0_ready) begin
            flit_d = req0_flit;
            ptr_d  = 1'b0;
        end else if (req1_ready) begin
            flit_d = req1_flit;
            ptr_d  = 1'b1;
        end

        if (txrsp_lcrdv && !issue) begin
            if (cnt_q == MAX_CRD) begin
                ovf_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (!txrsp_lcrdv && issue) begin
            cnt_d = cnt_q - 1'b1;
        end

        // Leaving RETURN looks at the post-update count so a late credit keeps us returning.
        case (state_q)
            ST_RUN:    if (txrsp_deact_req) state_d = ST_RETURN;
            ST_RETURN: if (cnt_d == '0) state_d = ST_DONE;
            ST_DONE:   if (!txrsp_deact_req) state_d = ST_RUN;
            default:   state_d = ST_RUN;
        endcase

        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
            ptr_q   <= 1'b1;
            flitv_q <= 1'b0;
            flit_q  <= '0;
            pend_q  <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            flitv_q <= flitv_d;
            flit_q  <= flit_d;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    assign txrspflitv       = flitv_q;
    assign txrspflit        = flit_q;
    assign txrspflitpend    = pend_q;
    assign txrsp_crd_ovf    = ovf_q;
    assign txrsp_deact_done = done_q;

endmodule

// File: tb/tb_hni_txrsp_ctl.sv
// Self-checking bench for hni_txrsp_ctl: directed scenarios then random traffic, all against a cycle model.

`ifndef CHIE_RSP_FLIT_RANGE
`define CHIE_RSP_FLIT_RANGE 72:0
`endif
`ifndef CHIE_RSP_FLIT_QOS_RANGE
`define CHIE_RSP_FLIT_QOS_RANGE 3:0
`endif

module tb_hni_txrsp_ctl;

    localparam int MAX_CRD = 15;

    logic                        clk = 1'b0;
    logic                        rst;
    logic                        txrsp_lcrdv;
    logic                        txrsp_deact_req;
    logic                        req0_valid;
    logic [`CHIE_RSP_FLIT_RANGE] req0_flit;
    logic                        req1_valid;
    logic [`CHIE_RSP_FLIT_RANGE] req1_flit;
    logic                        req0_ready;
    logic                        req1_ready;
    logic                        txrspflitpend;
    logic                        txrspflitv;
    logic [`CHIE_RSP_FLIT_RANGE] txrspflit;
    logic                        txrsp_deact_done;
    logic                        txrsp_crd_ovf;

    hni_txrsp_ctl #(.HNI_TXRSP_MAX_CRD(MAX_CRD)) dut (
        .clk              (clk),
        .rst              (rst),
        .txrsp_lcrdv      (txrsp_lcrdv),
        .txrsp_deact_req  (txrsp_deact_req),
        .req0_valid       (req0_valid),
        .req0_flit        (req0_flit),
        .req1_valid       (req1_valid),
        .req1_flit        (req1_flit),
        .req0_ready       (req0_ready),
        .req1_ready       (req1_ready),
        .txrspflitpend    (txrspflitpend),
        .txrspflitv       (txrspflitv),
        .txrspflit        (txrspflit),
        .txrsp_deact_done (txrsp_deact_done),
        .txrsp_crd_ovf    (txrsp_crd_ovf)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit verbose = 1'b1;

    // Reference model: credits held, link mode, last granted requester, expected registered outputs.
    int                          m_credits;
    string                       m_mode;
    int                          m_last;
    bit                          m_ovf;
    bit                          e_flitv;
    logic [`CHIE_RSP_FLIT_RANGE] e_flit;
    bit                          e_pend;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [`CHIE_RSP_FLIT_RANGE] rnd_flit();
        logic [95:0] r;
        r = {$urandom, $urandom, $urandom};
        return r[`CHIE_RSP_FLIT_RANGE];
    endfunction

    // Which requester the rules pick this cycle: -1 none, 0 or 1.
    function automatic int model_grant();
        int w;
        w = -1;
        if (m_mode == "RUN" && m_credits > 0) begin
            if (req0_valid && req1_valid) begin
                w = (m_last == 0) ? 1 : 0;
`ifdef HNI_TXRSP_QOS_PRIO_EN
                if (req0_flit[`CHIE_RSP_FLIT_QOS_RANGE] > req1_flit[`CHIE_RSP_FLIT_QOS_RANGE]) w = 0;
                else if (req1_flit[`CHIE_RSP_FLIT_QOS_RANGE] > req0_flit[`CHIE_RSP_FLIT_QOS_RANGE]) w = 1;
`endif
            end else if (req0_valid) begin
                w = 0;
            end else if (req1_valid) begin
                w = 1;
            end
        end
        return w;
    endfunction

    task automatic check_outputs(input string tag);
        chk({tag, ".flitv"}, 128'(txrspflitv), 128'(e_flitv));
        chk({tag, ".flit"}, 128'(txrspflit), 128'(e_flit));
        chk({tag, ".pend"}, 128'(txrspflitpend), 128'(e_pend));
        chk({tag, ".done"}, 128'(txrsp_deact_done), 128'(m_mode == "DONE"));
        chk({tag, ".ovf"}, 128'(txrsp_crd_ovf), 128'(m_ovf));
    endtask

    // One clock: drive inputs, check grants mid-cycle, advance the model at the edge, check outputs.
    task automatic cycle(input string tag, input bit r, input bit v0, input bit v1,
                         input bit lcrdv, input bit deact);
        int  g;
        bit  ret;
        bit  issued;
        rst = r; req0_valid = v0; req1_valid = v1;
        txrsp_lcrdv = lcrdv; txrsp_deact_req = deact;
        req0_flit = rnd_flit();
        req1_flit = rnd_flit();
        @(negedge clk);
        g = model_grant();
        if (!r) begin
            chk({tag, ".rdy0"}, 128'(req0_ready), 128'(g == 0));
            chk({tag, ".rdy1"}, 128'(req1_ready), 128'(g == 1));
        end
        @(posedge clk);
        #1;
        if (r) begin
            m_credits = 0; m_mode = "RUN"; m_last = 1; m_ovf = 0;
            e_flitv = 0; e_flit = '0; e_pend = 0;
        end else begin
            ret    = (m_mode == "RETURN") && (m_credits > 0);
            issued = (g >= 0) || ret;
            e_pend  = (m_mode == "RUN" && (v0 || v1)) || (m_mode == "RETURN");
            e_flitv = issued;
            e_flit  = (g == 0) ? req0_flit : (g == 1) ? req1_flit : '0;
            if (lcrdv && !issued) begin
                if (m_credits == MAX_CRD) m_ovf = 1;
                else m_credits++;
            end else if (issued && !lcrdv) begin
                m_credits--;
            end
            if (g >= 0) m_last = g;
            if (m_mode == "RUN" && deact) m_mode = "RETURN";
            else if (m_mode == "RETURN" && m_credits == 0) m_mode = "DONE";
            else if (m_mode == "DONE" && !deact) m_mode = "RUN";
        end
        check_outputs(tag);
        if (verbose && txrspflitv)
            $display("[TB] %s: flit %0h sent (grant=%0d credits=%0d mode=%s)",
                     tag, txrspflit, g, m_credits, m_mode);
    endtask

    task automatic credits(input string tag, input int n);
        for (int i = 0; i < n; i++) cycle(tag, 0, 0, 0, 1, 0);
    endtask

    initial begin
        rst = 1; txrsp_lcrdv = 0; txrsp_deact_req = 0;
        req0_valid = 0; req1_valid = 0; req0_flit = '0; req1_flit = '0;
        m_credits = 0; m_mode = "RUN"; m_last = 1; m_ovf = 0;
        e_flitv = 0; e_flit = '0; e_pend = 0;

        // Reset state, checked against fixed constants too.
        cycle("reset", 1, 0, 0, 0, 0);
        cycle("reset2", 1, 1, 1, 1, 1);
        chk("reset.flitv_const", 128'(txrspflitv), 128'(0));
        chk("reset.ovf_const", 128'(txrsp_crd_ovf), 128'(0));

        // Three credits, requester 0 for four cycles: three grants then stall.
        credits("crd3", 3);
        for (int i = 0; i < 4; i++) cycle("req0x4", 0, 1, 0, 0, 0);
        chk("req0x4.ready_last", 128'(req0_ready), 128'(0));
        cycle("idle", 0, 0, 0, 0, 0);

        // Two credits, both requesters valid: req0, req1, then nothing.
        cycle("rst_b", 1, 0, 0, 0, 0);
        credits("crd2", 2);
        for (int i = 0; i < 4; i++) cycle("both", 0, 1, 1, 0, 0);

        // One credit, credit arrives with the grant: still one left.
        cycle("rst_c", 1, 0, 0, 0, 0);
        credits("crd1", 1);
        cycle("crd_and_gnt", 0, 1, 0, 1, 0);
        cycle("gnt_again", 0, 1, 0, 0, 0);
        cycle("gnt_none", 0, 1, 0, 0, 0);

        // Deactivation with three held credits returns them, then DONE, then back to RUN.
        cycle("rst_d", 1, 0, 0, 0, 0);
        credits("crd3b", 3);
        cycle("deact", 0, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++) cycle("return", 0, 1, 0, 0, 1);
        chk("return.done_const", 128'(txrsp_deact_done), 128'(1));
        cycle("done_crd", 0, 0, 0, 1, 1);
        cycle("undeact", 0, 0, 0, 0, 0);
        cycle("run_again", 0, 1, 0, 0, 0);
        cycle("run_flit", 0, 0, 0, 0, 0);

        // Deactivation coincident with a grant: grant completes, remaining credit returned.
        cycle("rst_e", 1, 0, 0, 0, 0);
        credits("crd2b", 2);
        cycle("gnt_deact", 0, 1, 1, 0, 1);
        for (int i = 0; i < 3; i++) cycle("ret_e", 0, 1, 1, 0, 1);

        // Reset in the middle of RETURN discards the remaining credits.
        cycle("rst_f", 1, 0, 0, 0, 0);
        credits("crd3c", 3);
        cycle("deact_f", 0, 0, 0, 0, 1);
        cycle("ret_f", 0, 0, 0, 0, 1);
        cycle("rst_mid", 1, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) cycle("after_rst", 0, 0, 0, 0, 0);
        chk("after_rst.flitv_const", 128'(txrspflitv), 128'(0));

        // Overflow: fill to 15, one more credit sets the sticky flag.
        cycle("rst_g", 1, 0, 0, 0, 0);
        credits("fill", MAX_CRD + 1);
        chk("ovf.const", 128'(txrsp_crd_ovf), 128'(1));
        for (int i = 0; i < 3; i++) cycle("ovf_hold", 0, 1, 0, 0, 0);
        cycle("ovf_rst", 1, 0, 0, 0, 0);

        // Random traffic against the model.
        verbose = 1'b0;
        begin
            bit deact_lvl;
            deact_lvl = 0;
            for (int i = 0; i < 3000; i++) begin
                if ($urandom_range(0, 99) < 4) deact_lvl = ~deact_lvl;
                cycle("rand", ($urandom_range(0, 299) == 0),
                      ($urandom_range(0, 99) < 50), ($urandom_range(0, 99) < 50),
                      ($urandom_range(0, 99) < 35), deact_lvl);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hni_txrsp_ctl.md
HNI_TXRSP_CTL -- requirements
Module: hni_txrsp_ctl

Interface
REQ-001 Parameter: HNI_TXRSP_MAX_CRD, default 15, maximum link-layer TX RSP credits the counter may hold.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 txrsp_lcrdv  input  1  one link-layer credit granted by the receiver this cycle.
REQ-005 txrsp_deact_req  input  1  level from hni_link; requests link deactivation and return of all held credits.
REQ-006 req0_valid / req0_flit  input  1 / `CHIE_RSP_FLIT_RANGE  requester 0 (MSHR Comp responses).
REQ-007 req1_valid / req1_flit  input  1 / `CHIE_RSP_FLIT_RANGE  requester 1 (MSHR DBIDResp responses).
REQ-008 req0_ready / req1_ready  output  1 each  grant; the flit is accepted in any cycle where valid and ready are both 1.
REQ-009 txrspflitpend  output  1  registered early-warning that a flit may be sent next cycle.
REQ-010 txrspflitv / txrspflit  output  1 / `CHIE_RSP_FLIT_RANGE  registered flit to hni_link.
REQ-011 txrsp_deact_done  output  1  high while in state DONE.
REQ-012 txrsp_crd_ovf  output  1  sticky error; a credit arrived while the counter was at HNI_TXRSP_MAX_CRD.

Function
REQ-013 Credit counter: width `HNI_LL_RSP_CRD_CNT_WIDTH, unsigned.
- Counter +1 on txrsp_lcrdv.
- Counter -1 on each flit issued (a grant or an LCrdReturn).
- Both in the same cycle: counter unchanged.
REQ-014 txrsp_lcrdv at count == HNI_TXRSP_MAX_CRD with no simultaneous decrement: counter holds, txrsp_crd_ovf sets and stays set until rst.
REQ-015 FSM states: RUN, RETURN, DONE.
- Reset state: RUN.
- RUN to RETURN when txrsp_deact_req == 1.
- RETURN to DONE when the counter is 0 after this cycle's update.
- DONE to RUN when txrsp_deact_req == 0.
REQ-016 In RUN, at most one grant per cycle, and only when the counter is nonzero.
REQ-017 When counter == 0, req0_ready and req1_ready are 0.
REQ-018 req0_ready and req1_ready are combinational from the valids, the arbiter pointer, the counter and the state.
REQ-019 Round-robin arbitration between requester 0 and requester 1.
- A 1-bit pointer records the requester that was last granted.
- When both requesters are valid, the requester not last granted wins.
- The pointer updates only on a grant.
- Pointer reset value: 1, so requester 0 wins the first contention.
REQ-020 A lone valid requester is granted regardless of the pointer.
REQ-021 The granted flit appears on txrspflit with txrspflitv == 1 exactly one cycle after the grant.
REQ-022 txrspflit is all-zero whenever txrspflitv == 0.
REQ-023 In RETURN, no requester is granted.
- Each cycle with counter > 0, the block issues one RespLCrdReturn flit (all-zero flit, opcode 0x0) with one-cycle latency and decrements the counter.
- Credits arriving during RETURN are returned in the same way.
REQ-024 In DONE, no flits are issued; incoming credits still increment the counter.
REQ-025 txrspflitpend is registered and is set for the next cycle when either condition holds:
- state RUN and (req0_valid | req1_valid);
- state RETURN.
REQ-026 txrsp_deact_req asserting in the same cycle as a RUN grant: the grant completes, the counter decrements, and RETURN starts next cycle.

Reset
REQ-027 While rst == 1, the following take their reset values:
- state RUN;
- counter 0;
- pointer 1;
- txrspflitv 0;
- txrspflit 0;
- txrspflitpend 0;
- txrsp_crd_ovf 0;
- txrsp_deact_done 0.
REQ-028 Reset asserted mid-RETURN discards the counter; no further LCrdReturn flits are issued.

Configuration
REQ-029 Macro HNI_TXRSP_QOS_PRIO_EN.
- Defined: when both requesters are valid, the requester whose flit QoS field (`CHIE_RSP_FLIT_QOS_RANGE) is numerically higher wins; equal QoS falls back to REQ-019 round-robin.
- Undefined: pure round-robin, and no QoS field is decoded.

Verification
REQ-030 Reset, 3 lcrdv pulses, req0 valid for 4 cycles -> 3 grants, flits one cycle after each, 4th cycle req0_ready == 0, counter 0.
REQ-031 Counter 2, req0 and req1 both valid continuously -> grants alternate req0, req1; then both ready 0.
REQ-032 Counter 1, lcrdv and grant in the same cycle -> counter stays 1; next cycle another grant is allowed.
REQ-033 Counter 3, deact_req = 1 with req0 valid -> no grants; 3 consecutive all-zero txrspflitv flits; deact_done = 1 from the cycle after the 3rd LCrdReturn issues; deact_req = 0 -> RUN.
REQ-034 Counter at 15, lcrdv = 1 with no grant -> counter 15, txrsp_crd_ovf = 1 and held until rst.
REQ-035 With HNI_TXRSP_QOS_PRIO_EN defined, counter 2, req0 QoS 4 and req1 QoS 9 both valid -> req1 granted first, then req0.
